// File: rtl/board_pkg.sv
// rtl/board_pkg.sv - shared constants, cell codes and FSM states for the Connect-4 board store
package board_pkg;
   localparam int ROWS        = 6;
   localparam int COLS        = 7;
   localparam int ADDR_STRIDE = 7;
   localparam int ROW_W       = 2 * COLS;

   localparam logic [1:0] CELL_EMPTY = 2'd0;
   localparam logic [1:0] CELL_P1    = 2'd1;
   localparam logic [1:0] CELL_P2    = 2'd2;

   localparam logic [5:0] MAX_MOVES = 6'(ROWS * COLS);

   typedef enum logic [2:0] {IDLE, READ, SCAN, WRITE, ACK} state_e;

   function automatic logic [1:0] cell_at(input logic [ROW_W-1:0] row, input logic [2:0] col);
      logic [ROW_W-1:0] sh;
      sh = row >> {col, 1'b0};
      return sh[1:0];
   endfunction
endpackage

// File: rtl/board_mem_ctrl_if.sv
// rtl/board_mem_ctrl_if.sv - VGA row-read port plus game-FSM drop/clear port of the board store
interface board_mem_ctrl_if;
   import board_pkg::*;

   logic             rden;
   logic [5:0]       addr;
   logic [ROW_W-1:0] data;
   logic             ready;
   logic             drop_req;
   logic [2:0]       drop_col;
   logic [1:0]       drop_player;
   logic             drop_ack;
   logic             drop_ok;
   logic [2:0]       drop_row;
   logic             clear;
   logic [5:0]       move_count;
   logic             board_full;

   modport master (
      output rden, addr, drop_req, drop_col, drop_player, clear,
      input  data, ready, drop_ack, drop_ok, drop_row, move_count, board_full
   );

   modport slave (
      input  rden, addr, drop_req, drop_col, drop_player, clear,
      output data, ready, drop_ack, drop_ok, drop_row, move_count, board_full
   );
endinterface

// File: rtl/board_row_decode.sv
// rtl/board_row_decode.sv - maps a VGA row address (multiple of the stride) to a row index
module board_row_decode
   import board_pkg::*;
(
   input  logic [5:0] addr_i,
   output logic [2:0] row_o,
   output logic       valid_o
);
   always_comb begin
      row_o   = '0;
      valid_o = 1'b0;
      for (int r = 0; r < ROWS; r++) begin
         if (addr_i == 6'(r * ADDR_STRIDE)) begin
            row_o   = 3'(r);
            valid_o = 1'b1;
         end
      end
   end
endmodule

// File: rtl/board_mem_ctrl.sv
// rtl/board_mem_ctrl.sv - 6x7 board store with VGA row reads and gravity drops.
// Optional move counter / full-board rejection under BOARD_MOVE_COUNT_EN.
module board_mem_ctrl
   import board_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   board_mem_ctrl_if.slave bus
);
   localparam logic [2:0] ST_IDLE  = 3'(IDLE);
   localparam logic [2:0] ST_READ  = 3'(READ);
   localparam logic [2:0] ST_SCAN  = 3'(SCAN);
   localparam logic [2:0] ST_WRITE = 3'(WRITE);
   localparam logic [2:0] ST_ACK   = 3'(ACK);

   logic [2:0]       state_q, state_d;
   logic [ROW_W-1:0] rows_q [ROWS];
   logic [ROW_W-1:0] rows_d [ROWS];
   logic [2:0]       scan_q, scan_d;
   logic [2:0]       col_q, col_d;
   logic [1:0]       player_q, player_d;
   logic             rd_armed_q, rd_armed_d;
   logic [ROW_W-1:0] data_q, data_d;
   logic             ready_q, ready_d;
   logic             ack_q, ack_d;
   logic             ok_q, ok_d;
   logic [2:0]       row_q, row_d;
   logic             board_full;
   logic [2:0]       dec_row;
   logic             dec_valid;
   logic             bad_args;

   board_row_decode u_row_decode (
      .addr_i  (bus.addr),
      .row_o   (dec_row),
      .valid_o (dec_valid)
   );

   assign bad_args = (col_q > 3'd6) || !((player_q == CELL_P1) || (player_q == CELL_P2));

   always_comb begin
      state_d    = state_q;
      rows_d     = rows_q;
      scan_d     = scan_q;
      col_d      = col_q;
      player_d   = player_q;
      data_d     = data_q;
      ok_d       = ok_q;
      row_d      = row_q;
      ready_d    = 1'b0;
      ack_d      = 1'b0;
      // The arm only comes back once the VGA has released its request.
      rd_armed_d = bus.rden ? rd_armed_q : 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (bus.clear) begin
               for (int i = 0; i < ROWS; i++) rows_d[i] = '0;
            end else if (bus.rden && rd_armed_q) begin
               state_d    = ST_READ;
               ready_d    = 1'b1;
               data_d     = dec_valid ? rows_q[dec_row] : '0;
               rd_armed_d = 1'b0;
            end else if (bus.drop_req) begin
               state_d  = ST_SCAN;
               scan_d   = 3'd5;
               col_d    = bus.drop_col;
               player_d = bus.drop_player;
            end
         end
         ST_READ: state_d = ST_IDLE;
         ST_SCAN: begin
            if (bad_args || board_full) begin
               state_d = ST_ACK;
               ack_d   = 1'b1;
               ok_d    = 1'b0;
            end else if (cell_at(rows_q[scan_q], col_q) == CELL_EMPTY) begin
               state_d = ST_WRITE;
            end else if (scan_q != 3'd0) begin
               scan_d = scan_q - 3'd1;
            end else begin
               state_d = ST_ACK;
               ack_d   = 1'b1;
               ok_d    = 1'b0;
            end
         end
         ST_WRITE: begin
            // Target cell is known empty, so OR-ing the code in is a write.
            rows_d[scan_q] = rows_q[scan_q] | (ROW_W'(player_q) << {col_q, 1'b0});
            row_d   = scan_q;
            ok_d    = 1'b1;
            ack_d   = 1'b1;
            state_d = ST_ACK;
         end
         ST_ACK:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         for (int i = 0; i < ROWS; i++) rows_q[i] <= '0;
         scan_q     <= '0;
         col_q      <= '0;
         player_q   <= '0;
         rd_armed_q <= 1'b1;
         data_q     <= '0;
         ready_q    <= 1'b0;
         ack_q      <= 1'b0;
         ok_q       <= 1'b0;
         row_q      <= '0;
      end else begin
         state_q    <= state_d;
         rows_q     <= rows_d;
         scan_q     <= scan_d;
         col_q      <= col_d;
         player_q   <= player_d;
         rd_armed_q <= rd_armed_d;
         data_q     <= data_d;
         ready_q    <= ready_d;
         ack_q      <= ack_d;
         ok_q       <= ok_d;
         row_q      <= row_d;
      end
   end

`ifdef BOARD_MOVE_COUNT_EN
   logic [5:0] count_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else if (state_q == ST_IDLE && bus.clear) begin
         count_q <= '0;
      end else if (state_q == ST_WRITE) begin
         count_q <= count_q + 6'd1;
      end
   end

   assign board_full     = (count_q == MAX_MOVES);
   assign bus.move_count = count_q;
`else
   assign board_full     = 1'b0;
   assign bus.move_count = '0;
`endif

   assign bus.board_full = board_full;
   assign bus.data       = data_q;
   assign bus.ready      = ready_q;
   assign bus.drop_ack   = ack_q;
   assign bus.drop_ok    = ok_q;
   assign bus.drop_row   = row_q;
endmodule

// File: tb/tb_board_mem_ctrl.sv
// tb/tb_board_mem_ctrl.sv - scoreboard bench for board_mem_ctrl against a cell-array reference model
module tb_board_mem_ctrl;
   import board_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #20 clk = ~clk;

   board_mem_ctrl_if bus();

   board_mem_ctrl dut (
      .clk (clk),
      .rst (rst_n),
      .bus (bus)
   );

   typedef struct {
      int cyc;
      int data;
   } rd_exp_t;

   typedef struct {
      int cyc;
      int ok;
      int row;
      int cnt;
      int full;
   } dr_exp_t;

   rd_exp_t rd_q[$];
   dr_exp_t dr_q[$];

   int cyc = 0;
   int errors = 0;
   int checks = 0;
   int board[6][7];
   int moves = 0;
   int busy_until = -10;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, exp);
      end
   endtask

   function automatic int model_read(input int addr);
      int v = 0;
      if (addr % 7 == 0 && addr <= 35) begin
         for (int c = 0; c < 7; c++) v = v | (board[addr / 7][c] << (2 * c));
      end
      return v;
   endfunction

   function automatic void model_clear();
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 7; c++) board[r][c] = 0;
      moves = 0;
   endfunction

   // Monitor: every ready/drop_ack pulse must match the oldest outstanding expectation.
   rd_exp_t re;
   dr_exp_t de;
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.ready) begin
            if (rd_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_ready at cycle %0d: got ready=1, required 0", cyc);
            end else begin
               re = rd_q.pop_front();
               check("read_data", int'(bus.data), re.data);
               check("read_cycle", cyc, re.cyc);
            end
         end
         if (bus.drop_ack) begin
            if (dr_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_drop_ack at cycle %0d: got drop_ack=1, required 0", cyc);
            end else begin
               de = dr_q.pop_front();
               check("drop_ok", int'(bus.drop_ok), de.ok);
               check("drop_ack_cycle", cyc, de.cyc);
               if (de.ok != 0) check("drop_row", int'(bus.drop_row), de.row);
               check("move_count", int'(bus.move_count), de.cnt);
               check("board_full", int'(bus.board_full), de.full);
            end
         end
      end
   end

   task automatic do_drop(input int col, input int player);
      dr_exp_t e;
      int      n;
      int      lat;
      int      land;
      bit      reject;
      e.ok   = 0;
      e.row  = 0;
      lat    = 2;
      reject = (col > 6) || !(player == 1 || player == 2);
`ifdef BOARD_MOVE_COUNT_EN
      if (moves == 42) reject = 1;
`endif
      if (!reject) begin
         land = -1;
         for (int r = 0; r < 6; r++) if (board[r][col] == 0) land = r;
         if (land < 0) begin
            lat = 7;
         end else begin
            board[land][col] = player;
            moves++;
            e.ok  = 1;
            e.row = land;
            lat   = 8 - land;
         end
      end
`ifdef BOARD_MOVE_COUNT_EN
      e.cnt  = moves;
      e.full = (moves == 42) ? 1 : 0;
`else
      e.cnt  = 0;
      e.full = 0;
`endif
      e.cyc      = cyc + lat;
      busy_until = e.cyc;
      dr_q.push_back(e);
      bus.drop_col    = 3'(col);
      bus.drop_player = 2'(player);
      bus.drop_req    = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.drop_ack && n < 30);
      if (!bus.drop_ack) begin
         checks++;
         errors++;
         $display("FAIL drop_timeout col=%0d: got no drop_ack, required one within 30 cycles", col);
         void'(dr_q.pop_back());
      end
      bus.drop_req = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic do_read(input int addr, input int hold);
      rd_exp_t e;
      int      n;
      e.data = model_read(addr);
      e.cyc  = ((cyc > busy_until) ? cyc : busy_until + 1) + 1;
      rd_q.push_back(e);
      bus.addr = 6'(addr);
      bus.rden = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.ready && n < 30);
      if (!bus.ready) begin
         checks++;
         errors++;
         $display("FAIL read_timeout addr=%0d: got no ready, required one within 30 cycles", addr);
         void'(rd_q.pop_back());
      end
      repeat (hold) @(negedge clk);
      bus.rden = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      bus.clear = 1'b1;
      @(posedge clk);
      #1;
      bus.clear = 1'b0;
      model_clear();
      check("move_count_after_clear", int'(bus.move_count), 0);
   endtask

   initial begin
      #1600000;
      $display("FAIL watchdog: got no finish, required finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int op;
      rst_n           = 1'b0;
      bus.rden        = 1'b0;
      bus.addr        = '0;
      bus.drop_req    = 1'b0;
      bus.drop_col    = '0;
      bus.drop_player = '0;
      bus.clear       = 1'b0;
      model_clear();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_ready", int'(bus.ready), 0);
      check("reset_drop_ack", int'(bus.drop_ack), 0);
      check("reset_drop_ok", int'(bus.drop_ok), 0);
      check("reset_drop_row", int'(bus.drop_row), 0);
      check("reset_data", int'(bus.data), 0);
      check("reset_move_count", int'(bus.move_count), 0);
      check("reset_board_full", int'(bus.board_full), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Read with rden held long after ready: exactly one response.
      do_read(0, 5);
      do_drop(3, 1);
      do_read(35, 0);
      check("row5_after_first_drop", model_read(35), 14'h0040);

      do_clear();
      for (int k = 0; k < 6; k++) do_drop(0, (k % 2) + 1);
      do_drop(0, 1);
      do_read(0, 0);

      do_drop(7, 1);
      do_drop(2, 0);
      do_drop(4, 3);
      for (int r = 0; r < 6; r++) do_read(r * 7, 0);

      // Read raised while a full-column drop is scanning.
      fork
         do_drop(0, 2);
         begin
            repeat (2) begin
               @(posedge clk);
               #1;
            end
            do_read(0, 0);
         end
      join

      for (int i = 0; i < 200; i++) begin
         op = $urandom_range(0, 39);
         if (op == 0) begin
            do_clear();
         end else if (op < 16) begin
            if ($urandom_range(0, 1) == 0) do_read($urandom_range(0, 5) * 7, $urandom_range(0, 2));
            else do_read($urandom_range(0, 63), 0);
         end else begin
            do_drop($urandom_range(0, 7),
                    ($urandom_range(0, 9) == 0) ? $urandom_range(0, 1) * 3 : $urandom_range(1, 2));
         end
      end

      do_clear();
      for (int c = 0; c < 7; c++)
         for (int k = 0; k < 6; k++) do_drop(c, ((c + k) % 2) + 1);
      do_drop(3, 1);
      do_read(14, 0);
      do_clear();
      for (int r = 0; r < 6; r++) do_read(r * 7, 0);

      // Reset in the middle of a scan: no ack, board wiped.
      for (int k = 0; k < 4; k++) do_drop(5, (k % 2) + 1);
      bus.drop_col    = 3'd5;
      bus.drop_player = 2'd1;
      bus.drop_req    = 1'b1;
      repeat (3) @(negedge clk);
      rst_n        = 1'b0;
      bus.drop_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_clear();
      repeat (10) @(negedge clk);
      @(posedge clk);
      #1;
      check("move_count_after_reset", int'(bus.move_count), 0);
      for (int r = 0; r < 6; r++) do_read(r * 7, 0);

      repeat (3) @(posedge clk);
      check("read_queue_drained", rd_q.size(), 0);
      check("drop_queue_drained", dr_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
